if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage, i.e. the writer side of the IF/ID pipeline register.
- Owns the PC, issues word requests to instruction memory over a request/grant + response-valid handshake, and buffers returned words in a small FIFO.
- Presents pc_plus_4/inst together with the IF/ID write enable.
- Handles ID stalls and branch/jump redirects without losing or duplicating instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset.
- FIFO_DEPTH, 2, instruction buffer entries; also the cap on outstanding + buffered fetches (power of 2, >=2).

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- id_stall  input  1  ID cannot accept this cycle; IF/ID must hold.
- redirect  input  1  branch/jump taken; flush and refetch from redirect_pc.
- redirect_pc  input  32  target PC, word aligned.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  fetch address (current PC).
- imem_gnt  input  1  request accepted this cycle (when imem_req=1).
- imem_rvalid  input  1  response data valid; in-order, >=1 cycle after gnt.
- imem_rdata  input  32  instruction word.
- if_wena  output  1  write enable to IF/ID register.
- pc_plus_4  output  32  PC+4 of the presented instruction.
- inst  output  32  presented instruction word.

Behaviour:
- Reset (rst_n=0, async):
  - pc=RESET_PC; FIFO empty; outstanding=0; epoch=0; state=BOOT.
  - Outputs: imem_req=0, imem_addr=RESET_PC, if_wena=0, pc_plus_4=0, inst=0.
- FSM states: BOOT, RUN.
  - BOOT lasts exactly one cycle after reset release, then goes to RUN.
  - No requests are issued in BOOT.
- Issue (RUN):
  - imem_req=1 when outstanding+fifo_count < FIFO_DEPTH and redirect=0.
  - imem_addr=pc.
  - On imem_req & imem_gnt: pc<=pc+4 (32-bit wrap, 0xFFFF_FFFC -> 0x0000_0000); outstanding+1.
  - The PC of each request is tagged with the current epoch in a FIFO_DEPTH-entry in-flight queue.
- Response:
  - On imem_rvalid: pop the in-flight tag and decrement outstanding.
  - If tag epoch == current epoch, push {pc+4, rdata} into the FIFO; otherwise discard.
  - Push and pop in the same cycle are legal; the count is unchanged.
- Output:
  - if_wena = ~id_stall (1 also in BOOT after the first cycle? no: 0 in BOOT).
  - If FIFO is non-empty: inst/pc_plus_4 = head entry. If empty: inst=32'h0 (NOP bubble), pc_plus_4=0.
  - Head is popped when if_wena=1 and FIFO is non-empty.
  - While id_stall=1, the head is held and nothing is popped; issue continues until the credit limit.
- Redirect (takes priority over everything else in the same cycle):
  - FIFO cleared; epoch toggled; pc<=redirect_pc.
  - imem_req=0 in the redirect cycle.
  - if_wena = ~id_stall with inst=0, which inserts a bubble.
  - Responses already in flight return with the stale epoch and are discarded. outstanding still decrements, so credit is recovered.
  - A response arriving in the same cycle as the redirect is discarded.
  - Back-to-back redirects are legal; the last target wins.
  - Epoch is 1 bit. Correctness holds because outstanding <= FIFO_DEPTH and responses are in order.
- Boundaries:
  - FIFO full → no issue.
  - A response is never accepted into a full FIFO; the credit rule guarantees this, and the bench asserts it.
  - imem_rvalid with outstanding=0 is a protocol error; the bench asserts it never occurs.

Optional Feature:
- Macro: IF_FETCH_PERF_EN.
- When defined:
  - Adds output perf_stall_cycles [31:0]: increments every cycle with id_stall=1 & FIFO non-empty.
  - Adds output perf_flush_drops [15:0]: increments per discarded stale response.
  - Both saturate at all-ones and reset to 0.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, memory returns rdata=addr|0x1 one cycle after a grant that is always asserted → IF/ID sees inst 0x1,0x5,0x9 with pc_plus_4 4,8,12; the first non-bubble appears 3 cycles after rst_n rises.
- id_stall=1 for 5 cycles while streaming → inst/pc_plus_4 held, if_wena=0, imem_req drops once 2 are buffered/outstanding; after release the sequence continues with no gap or duplicate.
- redirect to 0x0000_0100 with 2 requests outstanding → both stale responses dropped; next valid inst comes from 0x100 with pc_plus_4=0x104.
- imem_gnt held low for 4 cycles → imem_addr stable, pc unchanged, IF/ID receives NOP bubbles (inst=0).
- rst_n asserted mid-stream with a response pending → all outputs reset immediately (async); fetch restarts at RESET_PC.
- With IF_FETCH_PERF_EN: 3-cycle stall plus one redirect dropping 2 → perf_stall_cycles=3, perf_flush_drops=2.

Source files
------------

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage feeding the IF/ID pipeline register.
// Owns the PC, requests words from instruction memory (req/gnt + rvalid),
// tags each in-flight request with a fetch epoch and buffers returned words
// in a small FIFO presented to ID as {pc_plus_4, inst} with if_wena.
// Optional build macro: IF_FETCH_PERF_EN adds saturating stall/flush counters.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_wena,
    output logic [31:0] pc_plus_4,
    output logic [31:0] inst
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [15:0] perf_flush_drops
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = FIFO_DEPTH[CW:0];

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [31:0] pc_q, pc_d;
    logic        epoch_q, epoch_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;

    // Instruction buffer: each entry is {pc_plus_4, inst}
    logic [FIFO_DEPTH-1:0][63:0] fifo_mem_q, fifo_mem_d;
    logic [AW-1:0] fifo_rd_q, fifo_rd_d;
    logic [AW-1:0] fifo_wr_q, fifo_wr_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;

    // In-flight tag queue: request PC plus the epoch it was issued in
    logic [FIFO_DEPTH-1:0][31:0] fl_pc_q, fl_pc_d;
    logic [FIFO_DEPTH-1:0]       fl_ep_q, fl_ep_d;
    logic [AW-1:0] fl_rd_q, fl_rd_d;
    logic [AW-1:0] fl_wr_q, fl_wr_d;

    logic        in_run;
    logic        fifo_empty;
    logic        show_head;
    logic        issue;
    logic        pop;
    logic        resp_keep;
    logic        resp_drop;
    logic [31:0] resp_pc;
    logic [CW:0] credit_used;

    // Handshake and IF/ID output decode
    always_comb begin
        in_run      = (state_q == RUN);
        fifo_empty  = (fifo_cnt_q == '0);
        credit_used = {1'b0, out_cnt_q} + {1'b0, fifo_cnt_q};
        imem_req    = in_run && !redirect && (credit_used < DEPTH_C);
        imem_addr   = pc_q;
        if_wena     = in_run && !id_stall;
        // A redirect cycle always presents a bubble, even if words are buffered
        show_head   = !fifo_empty && !redirect;
        inst        = show_head ? fifo_mem_q[fifo_rd_q][31:0]  : 32'h0;
        pc_plus_4   = show_head ? fifo_mem_q[fifo_rd_q][63:32] : 32'h0;
        issue       = imem_req && imem_gnt;
        pop         = if_wena && show_head;
        resp_pc     = fl_pc_q[fl_rd_q];
        resp_keep   = imem_rvalid && !redirect && (fl_ep_q[fl_rd_q] == epoch_q);
        resp_drop   = imem_rvalid && !resp_keep;
    end

    // FSM next state: BOOT is a single quiet cycle after reset release
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state for PC, epoch, credit counter, tag queue and buffer
    always_comb begin
        pc_d       = pc_q;
        epoch_d    = epoch_q;
        out_cnt_d  = out_cnt_q;
        fifo_mem_d = fifo_mem_q;
        fifo_rd_d  = fifo_rd_q;
        fifo_wr_d  = fifo_wr_q;
        fifo_cnt_d = fifo_cnt_q;
        fl_pc_d    = fl_pc_q;
        fl_ep_d    = fl_ep_q;
        fl_rd_d    = fl_rd_q;
        fl_wr_d    = fl_wr_q;

        if (issue) begin
            fl_pc_d[fl_wr_q] = pc_q;
            fl_ep_d[fl_wr_q] = epoch_q;
            fl_wr_d          = fl_wr_q + AW'(1);
            pc_d             = pc_q + 32'd4;
        end

        if (imem_rvalid) begin
            fl_rd_d = fl_rd_q + AW'(1);
        end

        if (issue && !(imem_rvalid && out_cnt_q != '0)) begin
            out_cnt_d = out_cnt_q + CW'(1);
        end else if (!issue && imem_rvalid && out_cnt_q != '0) begin
            out_cnt_d = out_cnt_q - CW'(1);
        end

        if (redirect) begin
            pc_d       = redirect_pc;
            epoch_d    = ~epoch_q;
            fifo_rd_d  = '0;
            fifo_wr_d  = '0;
            fifo_cnt_d = '0;
            // Retag every in-flight entry with the outgoing epoch so that it can
            // never match again, even if further redirects toggle the epoch back.
            fl_ep_d    = {FIFO_DEPTH{epoch_q}};
        end else begin
            if (resp_keep) begin
                fifo_mem_d[fifo_wr_q] = {resp_pc + 32'd4, imem_rdata};
                fifo_wr_d             = fifo_wr_q + AW'(1);
            end
            if (pop) begin
                fifo_rd_d = fifo_rd_q + AW'(1);
            end
            if (resp_keep && !pop) begin
                fifo_cnt_d = fifo_cnt_q + CW'(1);
            end else if (!resp_keep && pop) begin
                fifo_cnt_d = fifo_cnt_q - CW'(1);
            end
        end
    end

    // Fetch datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            epoch_q    <= 1'b0;
            out_cnt_q  <= '0;
            fifo_mem_q <= '0;
            fifo_rd_q  <= '0;
            fifo_wr_q  <= '0;
            fifo_cnt_q <= '0;
            fl_pc_q    <= '0;
            fl_ep_q    <= '0;
            fl_rd_q    <= '0;
            fl_wr_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            epoch_q    <= epoch_d;
            out_cnt_q  <= out_cnt_d;
            fifo_mem_q <= fifo_mem_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_cnt_q <= fifo_cnt_d;
            fl_pc_q    <= fl_pc_d;
            fl_ep_q    <= fl_ep_d;
            fl_rd_q    <= fl_rd_d;
            fl_wr_q    <= fl_wr_d;
        end
    end

`ifdef IF_FETCH_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Saturating counters: stalled cycles with work waiting, discarded responses
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (id_stall && !fifo_empty && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (resp_drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Performance counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign perf_stall_cycles = stall_cnt_q;
    assign perf_flush_drops  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: scoreboard bench for if_fetch_unit. A memory model answers
// granted requests with rdata = addr | 1 after a configurable latency; expected
// IF/ID words are queued at grant time and compared when delivered.
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        if_wena;
    logic [31:0] pc_plus_4;
    logic [31:0] inst;
`ifdef IF_FETCH_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [15:0] perf_flush_drops;
`endif

    if_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .id_stall(id_stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_wena(if_wena), .pc_plus_4(pc_plus_4), .inst(inst)
`ifdef IF_FETCH_PERF_EN
        , .perf_stall_cycles(perf_stall_cycles), .perf_flush_drops(perf_flush_drops)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc4;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          gen;
        int          due;
    } mreq_t;

    exp_t  sb[$];
    mreq_t mq[$];

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int lat = 1;
    int out_b = 0;
    int buf_b = 0;
    int gen = 0;
    int stall_b = 0;
    int drops_b = 0;
    int first_cyc = -1;
    int del_cnt = 0;
    logic        in_reset = 1'b1;
    logic        rel_req = 1'b0;
    logic [31:0] pc_b = RESET_PC;
    logic [31:0] first_inst = 32'h0;
    logic [31:0] last_inst = 32'h0;
    logic [31:0] last_pc4 = 32'h0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Compare DUT outputs against the model for this cycle, then advance the model
    task automatic sample();
        logic  granted;
        logic  exp_req;
        logic  stale;
        mreq_t e;
        exp_t  h;
        granted = imem_req & imem_gnt;
        exp_req = !in_reset && (cyc >= 1) && !redirect && (out_b + buf_b < DEPTH);
        check("req", {31'h0, imem_req}, {31'h0, exp_req});
        check("addr", imem_addr, pc_b);
        check("wena", {31'h0, if_wena}, {31'h0, !in_reset && (cyc >= 1) && !id_stall});
        if (id_stall && buf_b > 0) stall_b++;
        if (buf_b > 0 && !redirect) begin
            h = sb[0];
            check("inst", inst, h.inst);
            check("pc4", pc_plus_4, h.pc4);
            if (if_wena) begin
                void'(sb.pop_front());
                buf_b--;
                del_cnt++;
                last_inst = inst;
                last_pc4 = pc_plus_4;
                if (first_cyc < 0) begin
                    first_cyc = cyc;
                    first_inst = inst;
                end
            end
        end else begin
            check("bubble_inst", inst, 32'h0);
            check("bubble_pc4", pc_plus_4, 32'h0);
        end
        if (imem_rvalid) begin
            check("rv_outstanding", {31'h0, out_b > 0}, 32'h1);
            e = mq.pop_front();
            out_b--;
            stale = (e.gen != gen) || redirect;
            if (stale) begin
                drops_b++;
            end else begin
                check("fifo_ovf", {31'h0, buf_b < DEPTH}, 32'h1);
                buf_b++;
            end
        end
        if (granted) begin
            sb.push_back('{inst: imem_addr | 32'h1, pc4: imem_addr + 32'd4});
            mq.push_back('{addr: imem_addr, gen: gen, due: cyc + lat});
            out_b++;
            pc_b = pc_b + 32'd4;
        end
        if (redirect) begin
            sb.delete();
            buf_b = 0;
            gen++;
            pc_b = redirect_pc;
        end
    endtask

    // One clock cycle: drive at the falling edge, sample just before the rising edge
    task automatic cycle(input logic stall, input logic redir, input logic [31:0] rpc, input logic gnt);
        @(negedge clk);
        if (rel_req) begin
            rst_n = 1'b1;
            in_reset = 1'b0;
            rel_req = 1'b0;
            cyc = 0;
            first_cyc = -1;
        end
        id_stall = stall;
        redirect = redir;
        redirect_pc = rpc;
        imem_gnt = gnt;
        imem_rvalid = 1'b0;
        imem_rdata = 32'h0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata = mq[0].addr | 32'h1;
        end
        #4;
        sample();
        cyc++;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        imem_rvalid = 1'b0;
        id_stall = 1'b0;
        redirect = 1'b0;
        #1;
        check("rst_req", {31'h0, imem_req}, 32'h0);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_wena", {31'h0, if_wena}, 32'h0);
        check("rst_inst", inst, 32'h0);
        check("rst_pc4", pc_plus_4, 32'h0);
        sb.delete();
        mq.delete();
        out_b = 0;
        buf_b = 0;
        stall_b = 0;
        drops_b = 0;
        pc_b = RESET_PC;
        in_reset = 1'b1;
        repeat (n) cycle(1'b0, 1'b0, 32'h0, 1'b1);
        rel_req = 1'b1;
    endtask

    task automatic stream(input int n);
        repeat (n) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic wait_out(input int target, input string tag);
        int k;
        k = 0;
        while (out_b < target && k < 30) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1);
            k++;
        end
        check(tag, {31'h0, out_b >= target}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        logic [31:0] a0;
        int          d0;
        int          k;

        // Reset, then stream with single-cycle memory
        do_reset(3);
        lat = 1;
        stream(12);
        check("first_lat", first_cyc, 32'd3);
        check("first_inst", first_inst, 32'h1);

        // ID stall: head held, request drops at the credit limit
        repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b1);
        held = inst;
        repeat (2) cycle(1'b1, 1'b0, 32'h0, 1'b1);
        check("stall_hold", inst, held);
        check("stall_nz", {31'h0, held != 32'h0}, 32'h1);
        check("stall_req", {31'h0, imem_req}, 32'h0);
        stream(10);

        // Redirect with two requests outstanding
        lat = 3;
        wait_out(2, "redir_setup");
        cycle(1'b0, 1'b1, 32'h0000_0100, 1'b1);
        d0 = del_cnt;
        k = 0;
        while (del_cnt == d0 && k < 30) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1);
            k++;
        end
        check("redir_wait", {31'h0, del_cnt != d0}, 32'h1);
        check("redir_inst", last_inst, 32'h0000_0101);
        check("redir_pc4", last_pc4, 32'h0000_0104);
        stream(6);

        // Grant held low: address frozen, bubbles delivered
        lat = 1;
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        a0 = imem_addr;
        repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b0);
        check("gnt_addr", imem_addr, a0);
        check("gnt_bubble", inst, 32'h0);

        // PC wrap-around
        cycle(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
        stream(12);

        // Back-to-back redirects: last target wins
        lat = 3;
        wait_out(1, "b2b_setup");
        cycle(1'b0, 1'b1, 32'h0000_0200, 1'b1);
        cycle(1'b0, 1'b1, 32'h0000_0300, 1'b1);
        stream(12);
        check("b2b_target", last_inst & 32'hFFFF_FF00, 32'h0000_0300);

        // Asynchronous reset with a response pending
        lat = 2;
        wait_out(1, "mrst_setup");
        do_reset(2);
        lat = 1;
        stream(8);
        check("restart", first_inst, 32'h1);

        // Stall then flush for the performance counters
        stream(4);
        repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b1);
        stream(2);
        lat = 3;
        wait_out(2, "perf_setup");
        cycle(1'b0, 1'b1, 32'h0000_0040, 1'b1);
        stream(8);

        // Drain everything in flight
        k = 0;
        while ((sb.size() > 0 || mq.size() > 0) && k < 40) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b0);
            k++;
        end
        check("drain", sb.size(), 32'd0);
`ifdef IF_FETCH_PERF_EN
        check("perf_stall", perf_stall_cycles, stall_b);
        check("perf_drops", {16'h0, perf_flush_drops}, drops_b);
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
